// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fb_pkg                                                           |
// | Purpose : Framebuffer geometry, buffered pixel word and writer FSM states   |
// |           shared by fb_pixel_writer and fb_fifo.                           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fb_pkg;

  localparam int FB_W   = 640;
  localparam int FB_H   = 480;
  localparam int ADDR_W = 19;

  // One buffered pixel: linear word address plus packed {R,G,B} colour.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       rgb;
  } fb_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_fifo                                                          |
// | Purpose : Synchronous show-ahead FIFO of fb_word_t pixel words.            |
// | Ports   : clk, rst_n (async active-low), i_push/i_wdata write side,        |
// |           i_pop/o_head read side, o_full/o_empty occupancy flags.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  fb_word_t i_wdata,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output fb_word_t o_head
);

  localparam int AW = $clog2(DEPTH);

  fb_word_t        r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_pixel_writer                                                  |
// | Purpose : Clips the shader pixel stream, buffers it and turns each pixel   |
// |           into a linear framebuffer write over a req/ack memory port.      |
// | Ports   : clk, reset_n (async active-low)                                  |
// |           shader : write_pixel, x_pixel, y_pixel, R, G, B, done, pix_ready |
// |           memory : mem_req, mem_addr, mem_wdata, mem_ack                   |
// |           status : frame_done (pulse), overflow (sticky), clip_count       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_pixel_writer #(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write_pixel,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  input  logic              done,
  output logic              pix_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  import fb_pkg::*;

  fb_state_t         r_state;
  fb_state_t         w_state_nxt;
  logic              r_mem_req;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [23:0]       r_mem_wdata;
  logic              r_frame_done;
  logic              r_overflow;
  logic [15:0]       r_clip_count;
  logic              r_done_seen;
  logic              r_rearm_block;

  logic              w_in_range;
  logic              w_clip;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_frame_fire;
  logic              w_done_arm;
  logic [ADDR_W-1:0] w_addr;
  fb_word_t          w_push_word;
  fb_word_t          w_head;

  // ---------------------------------------------------------------- clipping
  assign w_in_range = ({22'd0, x_pixel} < FB_W) && ({22'd0, y_pixel} < FB_H);
  assign w_clip     = write_pixel && !w_in_range;

  // Modulo-2**ADDR_W arithmetic yields exactly the low ADDR_W bits of the
  // full-width y*FB_W + x, so the product is formed directly at ADDR_W.
  assign w_addr = ADDR_W'(y_pixel) * ADDR_W'(FB_W) + ADDR_W'(x_pixel);

  assign w_push_word.addr = w_addr;
  assign w_push_word.rgb  = {R, G, B};

  // A pop on the same edge frees an entry, so a full FIFO still accepts.
  assign w_push = write_pixel && w_in_range && (!w_full || w_pop);
  assign w_ovf  = write_pixel && w_in_range && w_full && !w_pop;

  fb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // --------------------------------------------------------------- write FSM
  // WRITE is occupied exactly while mem_req is high, so an ack seen in IDLE
  // is ignored without further qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_req_nxt;
      if (w_pop) begin
        r_mem_addr  <= w_head.addr;
        r_mem_wdata <= w_head.rgb;
      end
    end
  end

  // ------------------------------------------------------------ done / frame
  assign w_frame_fire = r_done_seen && w_empty && (r_state == IDLE);

  // After a frame completes with done still high, done only re-arms once a
  // new pixel arrives or done drops, giving one frame_done per drain.
  assign w_done_arm = done && (!r_rearm_block || w_push);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_seen   <= 1'b0;
      r_rearm_block <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_frame_fire;
      if (w_frame_fire) begin
        // A pixel pushed on the firing edge together with done starts a
        // new frame that is already marked complete.
        r_done_seen   <= done && w_push;
        r_rearm_block <= done;
      end else begin
        r_done_seen   <= r_done_seen || w_done_arm;
        r_rearm_block <= r_rearm_block && done && !w_push;
      end
    end
  end

  // -------------------------------------------------------- status counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_clip_count <= '0;
    end else begin
      if (w_ovf) r_overflow <= 1'b1;
      if (w_frame_fire) begin
        // A clip on the firing edge belongs to the next frame.
        r_clip_count <= w_clip ? 16'd1 : 16'd0;
      end else if (w_clip && (r_clip_count != 16'hFFFF)) begin
        r_clip_count <= r_clip_count + 16'd1;
      end
    end
  end

  assign pix_ready  = !w_full;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign clip_count = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fb_pixel_writer                                               |
// | Purpose : Scoreboard bench for fb_pixel_writer: directed cases plus        |
// |           randomized pixel frames against a behavioural model.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fb_pixel_writer;

  localparam int FB_W   = 640;
  localparam int FB_H   = 480;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              write_pixel = 1'b0;
  logic [9:0]        x_pixel = '0;
  logic [9:0]        y_pixel = '0;
  logic [7:0]        R = '0;
  logic [7:0]        G = '0;
  logic [7:0]        B = '0;
  logic              done = 1'b0;
  logic              pix_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic              frame_done;
  logic              overflow;
  logic [15:0]       clip_count;

  always #5 clk = ~clk;

  fb_pixel_writer #(
    .FB_W       (FB_W),
    .FB_H       (FB_H),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .write_pixel (write_pixel),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .R           (R),
    .G           (G),
    .B           (B),
    .done        (done),
    .pix_ready   (pix_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .clip_count  (clip_count)
  );

  int          n_checks   = 0;
  int          n_pass     = 0;
  int          n_writes   = 0;
  int          n_frames   = 0;
  int          clip_model = 0;
  logic [42:0] exp_q [$];
  logic        ack_level  = 1'b0;
  logic        ack_rand   = 1'b0;
  logic        prev_fd    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Memory side: ack is either a fixed level or random per cycle.
  always @(posedge clk) begin
    #2;
    mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : ack_level;
  end

  // Monitor: every accepted write is compared with the oldest expected pixel.
  always @(negedge clk) begin
    logic [42:0] e;
    if (mem_req && mem_ack) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e[42:24]));
        check("write_data", 64'(mem_wdata), 64'(e[23:0]));
      end
    end
    if (frame_done) begin
      n_frames++;
      check("frame_done_width", 64'(prev_fd), 64'(0));
      check("drained_at_frame_done", 64'(exp_q.size()), 64'(0));
    end
    prev_fd = frame_done;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one pixel for one edge; the model predicts clip or write.
  task automatic drive_pixel(input int x, input int y, input logic [23:0] rgb,
                             input logic dn, input logic acc);
    logic [42:0] ent;
    write_pixel = 1'b1;
    x_pixel     = 10'(x);
    y_pixel     = 10'(y);
    {R, G, B}   = rgb;
    done        = dn;
    if (x < FB_W && y < FB_H) begin
      if (acc) begin
        ent = {19'(y * FB_W + x), rgb};
        exp_q.push_back(ent);
      end
    end else if (clip_model < 65535) begin
      clip_model++;
    end
    @(posedge clk);
    #1;
    write_pixel = 1'b0;
    done        = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int start;
    start = n_frames;
    for (int i = 0; i < budget; i++) begin
      if (n_frames > start) break;
      cyc(1);
    end
    cyc(5);
    check("frame_pulses", 64'(n_frames - start), 64'(1));
    clip_model = 0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mem_req) break;
      cyc(1);
    end
    check("drain_queue", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_pix_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pix_ready) break;
      cyc(1);
    end
    check("pix_ready_wait", 64'(pix_ready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    logic [18:0] hold_addr;
    logic [23:0] hold_data;
    logic        dn;

    // ---------------- reset state
    cyc(3);
    check("rst_pix_ready",  64'(pix_ready),  64'(1));
    check("rst_mem_req",    64'(mem_req),    64'(0));
    check("rst_mem_addr",   64'(mem_addr),   64'(0));
    check("rst_mem_wdata",  64'(mem_wdata),  64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_overflow",   64'(overflow),   64'(0));
    check("rst_clip_count", 64'(clip_count), 64'(0));
    reset_n = 1'b1;
    ack_level = 1'b1;
    cyc(2);

    // ---------------- single pixel (10,2)
    drive_pixel(10, 2, 24'h112233, 1'b0, 1'b1);
    check("first_req_not_yet", 64'(mem_req), 64'(0));
    cyc(1);
    check("first_req_up",  64'(mem_req),   64'(1));
    check("single_addr",   64'(mem_addr),  64'(1290));
    check("single_data",   64'(mem_wdata), 64'(24'h112233));
    pulse_done();
    wait_frame(50);
    check("no_overflow", 64'(overflow), 64'(0));

    // ---------------- ack held low for 5 cycles
    ack_level = 1'b0;
    cyc(2);
    w0 = n_writes;
    drive_pixel(100, 7, 24'hABCDEF, 1'b0, 1'b1);
    cyc(1);
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    check("hold_req_up", 64'(mem_req), 64'(1));
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("hold_addr_stable", 64'(mem_addr),  64'(hold_addr));
      check("hold_data_stable", 64'(mem_wdata), 64'(hold_data));
    end
    ack_level = 1'b1;
    wait_drain(20);
    check("hold_one_write", 64'(n_writes - w0), 64'(1));

    // ---------------- clipping boundaries
    drive_pixel(640, 0, 24'h010203, 1'b0, 1'b1);
    drive_pixel(0, 480, 24'h040506, 1'b0, 1'b1);
    drive_pixel(639, 479, 24'h070809, 1'b0, 1'b1);
    check("clip_count_two", 64'(clip_count), 64'(clip_model));
    pulse_done();
    wait_frame(50);
    check("clip_cleared", 64'(clip_count), 64'(0));

    // ---------------- done on the same edge as the last pixel
    drive_pixel(3, 4, 24'h5A5A5A, 1'b1, 1'b1);
    wait_frame(50);

    // ---------------- overflow burst with memory stalled
    ack_level = 1'b0;
    cyc(2);
    w0 = n_writes;
    for (int i = 0; i < 20; i++)
      drive_pixel(i, 5, 24'($urandom), 1'b0, (i < DEPTH + 1) ? 1'b1 : 1'b0);
    check("burst_pix_ready_low", 64'(pix_ready), 64'(0));
    check("burst_overflow",      64'(overflow),  64'(1));
    cyc(20);
    check("burst_no_write_stalled", 64'(n_writes - w0), 64'(0));
    ack_level = 1'b1;
    wait_drain(100);
    check("burst_write_count", 64'(n_writes - w0), 64'(DEPTH + 1));
    check("burst_ready_again", 64'(pix_ready), 64'(1));
    check("overflow_sticky",   64'(overflow),  64'(1));

    // ---------------- reset mid-operation
    ack_level = 1'b0;
    cyc(2);
    for (int i = 0; i < 4; i++)
      drive_pixel(20 + i, 9, 24'($urandom), 1'b0, 1'b1);
    cyc(1);
    check("pre_reset_req", 64'(mem_req), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_req_drop",  64'(mem_req),   64'(0));
    check("reset_ready",     64'(pix_ready), 64'(1));
    check("reset_overflow",  64'(overflow),  64'(0));
    exp_q.delete();
    clip_model = 0;
    w0 = n_writes;
    cyc(3);
    reset_n = 1'b1;
    ack_level = 1'b1;
    cyc(20);
    check("post_reset_no_writes", 64'(n_writes - w0), 64'(0));
    check("post_reset_ready",     64'(pix_ready),     64'(1));
    check("post_reset_req",       64'(mem_req),       64'(0));

    // ---------------- randomized frames with random ack
    ack_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      dn = 1'b0;
      for (int k = 0; k < 30; k++) begin
        wait_pix_ready(100);
        dn = (k == 29) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_pixel(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                    24'($urandom), dn, 1'b1);
        if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(1, 3)));
      end
      check("rand_clip_count", 64'(clip_count), 64'(clip_model));
      if (!dn) pulse_done();
      wait_frame(500);
      check("rand_clip_cleared", 64'(clip_count), 64'(0));
    end
    ack_rand = 1'b0;
    cyc(5);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
